// File: rtl/spi_controller_core.sv
// spi_controller_core: bit-level SPI engine (mode 0, MSB first).
// Takes words from a valid/ready TX stream, shifts them out on pico/spi_clk,
// and captures poci into a registered RX word with a valid/ready handshake.
// A per-word tx_last flag frames cs_b, so multi-word bursts keep cs_b low.
// Optional feature: define SPI_CONTROLLER_CORE_LOOPBACK_EN to sample the
// internal pico instead of poci, so rx_data echoes the transmitted word.
module spi_controller_core #(
  parameter int WORD_WIDTH    = 8,
  parameter int CLK_DIV_WIDTH = 16
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div,
  input  logic [WORD_WIDTH-1:0]    tx_data,
  input  logic                     tx_last,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [WORD_WIDTH-1:0]    rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     busy,
  input  logic                     poci,
  output logic                     pico,
  output logic                     cs_b,
  output logic                     spi_clk
);

  localparam int BIT_CNT_W = $clog2(WORD_WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_HOLD,
    ST_TAIL,
    ST_GAP
  } state_e;

  state_e                   state_q, state_d;
  logic [CLK_DIV_WIDTH-1:0] div_q, div_d;
  logic [CLK_DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]     bits_q, bits_d;
  logic [WORD_WIDTH-1:0]    tx_sr_q, tx_sr_d;
  logic [WORD_WIDTH-1:0]    rx_sr_q, rx_sr_d;
  logic [WORD_WIDTH-1:0]    rx_data_q, rx_data_d;
  logic                     last_q, last_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     tx_ready_q, tx_ready_d;
  logic                     pico_q, pico_d;
  logic                     cs_b_q, cs_b_d;
  logic                     spi_clk_q, spi_clk_d;
  logic                     busy_q, busy_d;

  logic sample_bit;
  logic accept;
  logic consume;
  logic phase_done;

`ifdef SPI_CONTROLLER_CORE_LOOPBACK_EN
  // The captured bit is the data currently being driven on pico.
  logic unused_poci;
  assign unused_poci = poci;
  assign sample_bit  = pico_q;
`else
  assign sample_bit = poci;
`endif

  // tx_ready_q is only ever high in IDLE or HOLD with no pending RX word.
  assign accept     = tx_valid && tx_ready_q;
  assign consume    = rx_valid_q && rx_ready;
  assign phase_done = (cnt_q == '0);

  // Next-state and next-output computation for the bit engine.
  always_comb begin
    // NOTE: every _d signal gets its hold value first so no path leaves it
    // unassigned; that keeps this block purely combinational (no latches).
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    bits_d     = bits_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    last_d     = last_q;
    pico_d     = pico_q;
    rx_valid_d = consume ? 1'b0 : rx_valid_q;

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          state_d = ST_LOW;
          tx_sr_d = tx_data;
          pico_d  = tx_data[WORD_WIDTH-1];
          div_d   = clk_div;
          cnt_d   = clk_div;
          last_d  = tx_last;
          bits_d  = BIT_CNT_W'(WORD_WIDTH);
        end
      end
      ST_LOW: begin
        if (phase_done) begin
          // Rising spi_clk: capture the peripheral's bit.
          state_d = ST_HIGH;
          cnt_d   = div_q;
          rx_sr_d = {rx_sr_q[WORD_WIDTH-2:0], sample_bit};
          bits_d  = bits_q - BIT_CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CLK_DIV_WIDTH'(1);
        end
      end
      ST_HIGH: begin
        if (phase_done) begin
          cnt_d = div_q;
          if (bits_q != '0) begin
            // Falling spi_clk: present the next bit.
            state_d = ST_LOW;
            tx_sr_d = tx_sr_q << 1;
            pico_d  = tx_sr_q[WORD_WIDTH-2];
          end else begin
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            state_d    = last_q ? ST_TAIL : ST_HOLD;
          end
        end else begin
          cnt_d = cnt_q - CLK_DIV_WIDTH'(1);
        end
      end
      ST_TAIL: begin
        if (phase_done) begin
          state_d = ST_GAP;
          cnt_d   = div_q;
          pico_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CLK_DIV_WIDTH'(1);
        end
      end
      ST_GAP: begin
        if (phase_done) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CLK_DIV_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin outputs are derived from the next state so they register cleanly.
    cs_b_d     = (state_d == ST_IDLE) || (state_d == ST_GAP);
    spi_clk_d  = (state_d == ST_HIGH);
    busy_d     = (state_d != ST_IDLE);
    tx_ready_d = ((state_d == ST_IDLE) || (state_d == ST_HOLD)) && !rx_valid_d;
  end

  // FSM state, datapath and registered outputs; reset drops any partial word.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      bits_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      last_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      pico_q     <= 1'b0;
      cs_b_q     <= 1'b1;
      spi_clk_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register sees the pre-edge
      // values of the others, independent of statement order.
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      bits_q     <= bits_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      last_q     <= last_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      pico_q     <= pico_d;
      cs_b_q     <= cs_b_d;
      spi_clk_q  <= spi_clk_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign pico     = pico_q;
  assign cs_b     = cs_b_q;
  assign spi_clk  = spi_clk_q;

endmodule

// File: tb/tb_spi_controller_core.sv
// tb_spi_controller_core: self-checking bench for spi_controller_core.
// A timeline model (cycles since accept) predicts every output each cycle;
// directed sections pin literal timings; a randomized burst stresses flow control.
module tb_spi_controller_core;

  localparam int W  = 8;
  localparam int DW = 16;
`ifdef SPI_CONTROLLER_CORE_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [DW-1:0] clk_div  = '0;
  logic [W-1:0]  tx_data  = '0;
  logic          tx_last  = 1'b0;
  logic          tx_valid = 1'b0;
  logic          rx_ready = 1'b0;
  logic          poci     = 1'b0;
  logic          tx_ready, rx_valid, busy, pico, cs_b, spi_clk;
  logic [W-1:0]  rx_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic         rand_rx   = 1'b0;
  logic         poci_zero = 1'b0;
  logic [W-1:0] poci_word = '0;

  always #5 clk = ~clk;

  spi_controller_core #(.WORD_WIDTH(W), .CLK_DIV_WIDTH(DW)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .clk_div      (clk_div),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .busy         (busy),
    .poci         (poci),
    .pico         (pico),
    .cs_b         (cs_b),
    .spi_clk      (spi_clk)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A word is a timeline: t = 1 .. 2*W*h cycles after accept (h = clk_div+1),
  // phase p = (t-1)/h, spi_clk high on odd phases, pico = bit p/2 MSB first.
  typedef enum int {M_IDLE, M_WORD, M_HOLD, M_POST} mmode_e;
  mmode_e       m_mode    = M_IDLE;
  int           m_t       = 0;
  int           m_u       = 0;
  int           m_h       = 1;
  int           m_acc_cnt = 0;
  logic [W-1:0] m_word    = '0;
  logic [W-1:0] m_rxw     = '0;
  logic [W-1:0] m_pociw   = '0;
  logic [W-1:0] m_rxd     = '0;
  logic         m_last    = 1'b0;
  logic         m_rxv     = 1'b0;
  logic         m_rstf    = 1'b1;

  function automatic logic m_tx_ready();
    return !m_rstf && (m_mode == M_IDLE || m_mode == M_HOLD) && !m_rxv;
  endfunction

  function automatic logic [W+5:0] model_outputs();
    logic e_cs = 1'b1;
    logic e_sc = 1'b0;
    logic e_pi = 1'b0;
    logic e_bz = 1'b0;
    int   p;
    case (m_mode)
      M_WORD: begin
        p    = (m_t - 1) / m_h;
        e_cs = 1'b0;
        e_sc = (p % 2) == 1;
        e_pi = m_word[W-1-p/2];
        e_bz = 1'b1;
      end
      M_HOLD: begin
        e_cs = 1'b0;
        e_pi = m_word[0];
        e_bz = 1'b1;
      end
      M_POST: begin
        e_bz = 1'b1;
        if (m_u <= m_h) begin
          e_cs = 1'b0;
          e_pi = m_word[0];
        end
      end
      default: ;
    endcase
    return {e_cs, e_sc, e_pi, e_bz, m_tx_ready(), m_rxv, m_rxd};
  endfunction

  // Model advance on each clock edge; asynchronous reset mirrors the pins.
  always @(posedge clk or negedge rst_n) begin : model
    logic acc, cons, done;
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_rxv  = 1'b0;
      m_rxd  = '0;
      m_rstf = 1'b1;
    end else begin
      acc    = m_tx_ready() && tx_valid;
      cons   = m_rxv && rx_ready;
      done   = 1'b0;
      m_rstf = 1'b0;
      case (m_mode)
        M_IDLE, M_HOLD: begin
          if (acc) begin
            m_mode  = M_WORD;
            m_t     = 1;
            m_word  = tx_data;
            m_h     = int'(clk_div) + 1;
            m_last  = tx_last;
            m_pociw = poci_word;
            m_rxw   = LOOPBACK ? tx_data : poci_word;
            m_acc_cnt++;
          end
        end
        M_WORD: begin
          if (m_t == 2 * W * m_h) begin
            done  = 1'b1;
            m_rxd = m_rxw;
            if (m_last) begin
              m_mode = M_POST;
              m_u    = 1;
            end else begin
              m_mode = M_HOLD;
            end
          end else begin
            m_t++;
          end
        end
        M_POST: begin
          if (m_u == 2 * m_h) m_mode = M_IDLE;
          else m_u++;
        end
        default: ;
      endcase
      m_rxv = done ? 1'b1 : (cons ? 1'b0 : m_rxv);
    end
  end

  // Peripheral: valid data during LOW phases, noise elsewhere.
  always @(negedge clk) begin : peripheral
    int p;
    if (poci_zero) begin
      poci = 1'b0;
    end else if (m_mode == M_WORD && (((m_t - 1) / m_h) % 2) == 0) begin
      p    = (m_t - 1) / m_h;
      poci = m_pociw[W-1-p/2];
    end else begin
      poci = 1'($urandom);
    end
  end

  // Random consumer back-pressure when enabled.
  always @(negedge clk) begin
    if (rand_rx) rx_ready = 1'($urandom);
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("cycle", 64'({cs_b, spi_clk, pico, busy, tx_ready, rx_valid, rx_data}),
          64'(model_outputs()));
  end

  // Edge counters for burst-shape checks.
  int   mon_sclk_rises = 0;
  int   mon_csb_rises  = 0;
  int   mon_rxv_rises  = 0;
  logic pv_sclk = 1'b0, pv_csb = 1'b1, pv_rxv = 1'b0;
  always @(negedge clk) begin
    if (spi_clk && !pv_sclk) mon_sclk_rises++;
    if (cs_b && !pv_csb) mon_csb_rises++;
    if (rx_valid && !pv_rxv) mon_rxv_rises++;
    pv_sclk = spi_clk;
    pv_csb  = cs_b;
    pv_rxv  = rx_valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_word(input logic [W-1:0] d, input logic last);
    int a0 = m_acc_cnt;
    int n  = 0;
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (m_acc_cnt == a0 && n < 3000);
    tx_valid = 1'b0;
    check("send_accept", 64'(m_acc_cnt - a0), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(m_mode == M_IDLE && !m_rxv) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n < 3000), 64'd1);
  endtask

  function automatic logic [W-1:0] pick(input logic [W-1:0] lb, input logic [W-1:0] ext);
    return LOOPBACK ? lb : ext;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    int s_r, s_c, s_v;

    // Reset values, then first cycle after release.
    repeat (3) @(negedge clk);
    check("reset_state", 64'({cs_b, spi_clk, pico, tx_ready, rx_valid, busy, rx_data}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
    rst_n = 1'b1;
    #1 check("tx_ready_before_edge", 64'(tx_ready), 64'd0);
    @(negedge clk);
    check("tx_ready_after_release", 64'(tx_ready), 64'd1);

    // Single word 0xA5, tx_last=1, clk_div=0, peripheral returns 0x3C.
    begin
      logic [W-1:0] pseq = '0;
      int           nr   = 0;
      logic         pv   = 1'b0;
      rx_ready  = 1'b1;
      clk_div   = '0;
      poci_word = 8'h3C;
      send_word(8'hA5, 1'b1);
      for (int o = 1; o <= 19; o++) begin
        if (spi_clk && !pv) begin
          pseq = {pseq[W-2:0], pico};
          nr++;
        end
        if (o == 1) check("t1_csb_fall", 64'({cs_b, spi_clk}), 64'b00);
        if (o == 2) check("t1_first_rise", 64'(spi_clk), 64'd1);
        if (o == 17) check("t1_rx_done", 64'({cs_b, rx_valid, rx_data}),
                           64'({1'b0, 1'b1, pick(8'hA5, 8'h3C)}));
        if (o == 18) check("t1_csb_rise", 64'({cs_b, tx_ready}), 64'b10);
        if (o == 19) check("t1_tx_ready", 64'({cs_b, tx_ready}), 64'b11);
        pv = spi_clk;
        if (o < 19) @(negedge clk);
      end
      check("t1_pico_seq", 64'(pseq), 64'b1010_0101);
      check("t1_rises", 64'(nr), 64'd8);
    end

    // Two-word burst with rx_ready high: one continuous cs_b frame.
    s_r = mon_sclk_rises;
    s_c = mon_csb_rises;
    s_v = mon_rxv_rises;
    poci_word = 8'hC1;
    send_word(8'h12, 1'b0);
    poci_word = 8'h2D;
    send_word(8'h34, 1'b1);
    wait_idle("t2_idle");
    repeat (3) @(negedge clk);
    check("t2_sclk_rises", 64'(mon_sclk_rises - s_r), 64'd16);
    check("t2_csb_rises", 64'(mon_csb_rises - s_c), 64'd1);
    check("t2_rxv_pulses", 64'(mon_rxv_rises - s_v), 64'd2);
    check("t2_last_rx", 64'(rx_data), 64'(pick(8'h34, 8'h2D)));

    // Stall in HOLD while rx_ready is low.
    rx_ready  = 1'b0;
    clk_div   = 16'd1;
    poci_word = 8'hE7;
    send_word(8'h5A, 1'b0);
    poci_word = 8'h3B;
    fork
      send_word(8'h96, 1'b1);
      begin
        int n = 0;
        while (m_mode != M_HOLD && n < 200) begin
          @(negedge clk);
          n++;
        end
        repeat (10) @(negedge clk);
        check("t3_stall", 64'({cs_b, tx_ready, rx_valid, busy, rx_data}),
              64'({1'b0, 1'b0, 1'b1, 1'b1, pick(8'h5A, 8'hE7)}));
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("t3_released", 64'({cs_b, tx_ready, rx_valid}), 64'b010);
        @(negedge clk);
        check("t3_word2_start", 64'({cs_b, tx_ready, spi_clk, busy}), 64'b0001);
      end
    join
    rx_ready = 1'b1;
    wait_idle("t3_idle");
    check("t3_rx2", 64'(rx_data), 64'(pick(8'h96, 8'h3B)));

    // clk_div=3: 4-cycle phases, 64-cycle word; a mid-word change is ignored.
    begin
      int o = 1;
      clk_div   = 16'd3;
      poci_word = 8'h4D;
      send_word(8'h6B, 1'b1);
      clk_div = 16'd0;
      while (!rx_valid && o < 200) begin
        if (o == 4) check("t4_low4", 64'(spi_clk), 64'd0);
        if (o == 5) check("t4_high_start", 64'(spi_clk), 64'd1);
        if (o == 8) check("t4_high4", 64'(spi_clk), 64'd1);
        if (o == 9) check("t4_low_again", 64'(spi_clk), 64'd0);
        @(negedge clk);
        o++;
      end
      check("t4_word_time", 64'(o), 64'd65);
      wait_idle("t4_idle");
    end

    // Asynchronous reset after the third spi_clk rise, then a clean word.
    begin
      int   r  = 0;
      int   n  = 0;
      logic pv = 1'b0;
      clk_div   = 16'd1;
      poci_word = 8'h99;
      send_word(8'hF0, 1'b1);
      while (r < 3 && n < 200) begin
        if (spi_clk && !pv) r++;
        pv = spi_clk;
        if (r < 3) begin
          @(negedge clk);
          n++;
        end
      end
      #2 rst_n = 1'b0;
      #1 check("t5_async_reset", 64'({cs_b, spi_clk, rx_valid, pico, busy}), 64'b10000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_ready_again", 64'(tx_ready), 64'd1);
      poci_word = 8'h7E;
      send_word(8'h81, 1'b1);
      wait_idle("t5_idle");
      check("t5_clean_word", 64'(rx_data), 64'(pick(8'h81, 8'h7E)));
    end

    // Randomized traffic with random back-pressure and divider changes.
    rand_rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      clk_div   = DW'($urandom_range(0, 3));
      poci_word = W'($urandom);
      send_word(W'($urandom), (i == 39) ? 1'b1 : 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rand_rx  = 1'b0;
    rx_ready = 1'b1;
    wait_idle("rand_idle");

`ifdef SPI_CONTROLLER_CORE_LOOPBACK_EN
    // Loopback: poci held low, rx_data must echo the transmitted word.
    poci_zero = 1'b1;
    clk_div   = 16'd0;
    send_word(8'hC3, 1'b1);
    wait_idle("lb_idle");
    check("lb_echo", 64'(rx_data), 64'h0C3);
    poci_zero = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
